reg_writeback_unit: RTL and testbench

//  Writeback stage directly upstream of the register file. Merges single-cycle ALU results with
//  out-of-order-latency load returns, and owns the dataIn/writeSelect/writeEnable write port.

---
 rtl/reg_writeback_unit.sv | 184 ++++++++++++++++++
 tb/tb_reg_writeback_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_unit.sv
// ---------------------------------------------------------------------------
// reg_writeback_unit
//
// Writeback stage directly in front of the register file. ALU results are
// written one cycle after they arrive. Load returns are buffered in a small
// FIFO and drained whenever the ALU is not writing. The unit owns the
// register-file write port and tracks which registers still wait for a load,
// so decode can stall on RAW/WAW hazards.
//
// Build option:
//   WB_FORWARD_EN  defined   -> fwdA/fwdB bypass ports exist; hazard covers
//                               only the busy scoreboard.
//                  undefined -> no bypass ports; hazard also covers a source
//                               that matches the write in flight to the RF.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   alu_valid/rd/data   single-cycle ALU result (never stalled)
//   ld_issue_valid/rd   load sent to memory; marks its rd busy
//   ld_ret_valid/rd/data, ld_ret_ready   load-return handshake into the FIFO
//   chkA_rd, chkB_rd, chkD_rd            decode sources / destination
//   hazard              decode must stall (combinational)
//   busy_vec            one bit per register, set while a load is outstanding
//   rf_dataIn, rf_writeSelect, rf_writeEnable   registered RF write port
//   fwdA_hit/data, fwdB_hit/data        bypass of the in-flight RF write
//                                       (WB_FORWARD_EN only)
// ---------------------------------------------------------------------------
module reg_writeback_unit #(
   parameter int DATA_W    = 32,
   parameter int REG_AW    = 5,
   parameter int LDQ_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     alu_valid,
   input  logic [REG_AW-1:0]        alu_rd,
   input  logic [DATA_W-1:0]        alu_data,
   input  logic                     ld_issue_valid,
   input  logic [REG_AW-1:0]        ld_issue_rd,
   input  logic                     ld_ret_valid,
   input  logic [REG_AW-1:0]        ld_ret_rd,
   input  logic [DATA_W-1:0]        ld_ret_data,
   output logic                     ld_ret_ready,
   input  logic [REG_AW-1:0]        chkA_rd,
   input  logic [REG_AW-1:0]        chkB_rd,
   input  logic [REG_AW-1:0]        chkD_rd,
   output logic                     hazard,
`ifdef WB_FORWARD_EN
   output logic                     fwdA_hit,
   output logic                     fwdB_hit,
   output logic [DATA_W-1:0]        fwdA_data,
   output logic [DATA_W-1:0]        fwdB_data,
`endif
   output logic [(1<<REG_AW)-1:0]   busy_vec,
   output logic [DATA_W-1:0]        rf_dataIn,
   output logic [REG_AW-1:0]        rf_writeSelect,
   output logic                     rf_writeEnable
);

   localparam int              PTR_W   = $clog2(LDQ_DEPTH);
   localparam int              NREG    = 1 << REG_AW;
   localparam logic [PTR_W:0]  C_DEPTH = (PTR_W+1)'(LDQ_DEPTH);

   // Load-return FIFO
   logic [REG_AW-1:0] r_q_rd   [LDQ_DEPTH];
   logic [DATA_W-1:0] r_q_data [LDQ_DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [PTR_W:0]    r_count;

   // Scoreboard and RF write port
   logic [NREG-1:0]   r_busy;
   logic [NREG-1:0]   w_busy_next;
   logic              r_rf_we;
   logic [REG_AW-1:0] r_rf_sel;
   logic [DATA_W-1:0] r_rf_data;

   logic              w_alu_wr;
   logic              w_push;
   logic              w_pop;
   logic [REG_AW-1:0] w_head_rd;
   logic [DATA_W-1:0] w_head_data;
   logic              w_busy_hit;
   logic              w_hit_a;
   logic              w_hit_b;

   // Ready comes from the registered count only: a full queue refuses a
   // return even in a cycle where it also pops.
   assign ld_ret_ready = (r_count < C_DEPTH);
   assign w_push       = ld_ret_valid & ld_ret_ready;

   // An ALU write to r0 is dropped and does not take the port from the queue.
   assign w_alu_wr     = alu_valid & (alu_rd != '0);
   assign w_pop        = ~w_alu_wr & (r_count != '0);
   assign w_head_rd    = r_q_rd[r_rd_ptr];
   assign w_head_data  = r_q_data[r_rd_ptr];

   // NOTE: FIFO storage has no reset; r_count alone says which slots are valid,
   // so clearing the array would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_rd[r_wr_ptr]   <= ld_ret_rd;
         r_q_data[r_wr_ptr] <= ld_ret_data;
      end
   end

   // NOTE: every clocked block uses non-blocking assignments so all registers
   // see pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // RF write port: ALU has priority, otherwise the queue head drains.
   // A popped r0 load is consumed silently.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rf_we   <= 1'b0;
         r_rf_sel  <= '0;
         r_rf_data <= '0;
      end else begin
         r_rf_we <= 1'b0;
         if (w_alu_wr) begin
            r_rf_we   <= 1'b1;
            r_rf_sel  <= alu_rd;
            r_rf_data <= alu_data;
         end else if (w_pop && (w_head_rd != '0)) begin
            r_rf_we   <= 1'b1;
            r_rf_sel  <= w_head_rd;
            r_rf_data <= w_head_data;
         end
      end
   end

   // Scoreboard: the pop clears first, the issue sets afterwards, so a set and
   // clear of the same register in one cycle leaves it busy.
   always_comb begin
      // NOTE: the default copy comes first so every path assigns the vector
      // and no latch is inferred.
      w_busy_next = r_busy;
      if (w_pop)          w_busy_next[w_head_rd]   = 1'b0;
      if (ld_issue_valid) w_busy_next[ld_issue_rd] = 1'b1;
      w_busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) r_busy <= '0;
      else       r_busy <= w_busy_next;
   end

   // Busy bit 0 is never set, so r0 never raises the scoreboard term.
   assign w_busy_hit = r_busy[chkA_rd] | r_busy[chkB_rd] | r_busy[chkD_rd];
   assign w_hit_a    = r_rf_we & (r_rf_sel == chkA_rd) & (chkA_rd != '0);
   assign w_hit_b    = r_rf_we & (r_rf_sel == chkB_rd) & (chkB_rd != '0);

`ifdef WB_FORWARD_EN
   assign fwdA_hit  = w_hit_a;
   assign fwdB_hit  = w_hit_b;
   assign fwdA_data = r_rf_data;
   assign fwdB_data = r_rf_data;
   assign hazard    = w_busy_hit;
`else
   // Without bypass, a source being written this cycle is not yet readable
   // from the RF; stall one cycle.
   assign hazard    = w_busy_hit | w_hit_a | w_hit_b;
`endif

   assign busy_vec       = r_busy;
   assign rf_dataIn      = r_rf_data;
   assign rf_writeSelect = r_rf_sel;
   assign rf_writeEnable = r_rf_we;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_reg_writeback_unit
//
// Directed scenarios followed by random traffic. A transaction-level model
// (a queue of pending load returns, a busy bit array and the expected RF
// write) predicts every output each cycle.
// ---------------------------------------------------------------------------
module tb_reg_writeback_unit;

   localparam int DATA_W = 32;
   localparam int REG_AW = 5;
   localparam int DEPTH  = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              alu_valid;
   logic [REG_AW-1:0] alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              ld_issue_valid;
   logic [REG_AW-1:0] ld_issue_rd;
   logic              ld_ret_valid;
   logic [REG_AW-1:0] ld_ret_rd;
   logic [DATA_W-1:0] ld_ret_data;
   logic              ld_ret_ready;
   logic [REG_AW-1:0] chkA_rd;
   logic [REG_AW-1:0] chkB_rd;
   logic [REG_AW-1:0] chkD_rd;
   logic              hazard;
   logic [31:0]       busy_vec;
   logic [DATA_W-1:0] rf_dataIn;
   logic [REG_AW-1:0] rf_writeSelect;
   logic              rf_writeEnable;
`ifdef WB_FORWARD_EN
   logic              fwdA_hit;
   logic              fwdB_hit;
   logic [DATA_W-1:0] fwdA_data;
   logic [DATA_W-1:0] fwdB_data;
`endif

   reg_writeback_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .LDQ_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .reset          (reset),
      .alu_valid      (alu_valid),
      .alu_rd         (alu_rd),
      .alu_data       (alu_data),
      .ld_issue_valid (ld_issue_valid),
      .ld_issue_rd    (ld_issue_rd),
      .ld_ret_valid   (ld_ret_valid),
      .ld_ret_rd      (ld_ret_rd),
      .ld_ret_data    (ld_ret_data),
      .ld_ret_ready   (ld_ret_ready),
      .chkA_rd        (chkA_rd),
      .chkB_rd        (chkB_rd),
      .chkD_rd        (chkD_rd),
      .hazard         (hazard),
`ifdef WB_FORWARD_EN
      .fwdA_hit       (fwdA_hit),
      .fwdB_hit       (fwdB_hit),
      .fwdA_data      (fwdA_data),
      .fwdB_data      (fwdB_data),
`endif
      .busy_vec       (busy_vec),
      .rf_dataIn      (rf_dataIn),
      .rf_writeSelect (rf_writeSelect),
      .rf_writeEnable (rf_writeEnable)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [REG_AW-1:0] rd;
      logic [DATA_W-1:0] data;
   } ld_t;

   // Reference model state
   ld_t               mq[$];
   logic [31:0]       mbusy;
   logic              exp_we;
   logic [REG_AW-1:0] exp_sel;
   logic [DATA_W-1:0] exp_data;
   bit                chk_sel;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      alu_valid      = 1'b0;
      alu_rd         = '0;
      alu_data       = '0;
      ld_issue_valid = 1'b0;
      ld_issue_rd    = '0;
      ld_ret_valid   = 1'b0;
      ld_ret_rd      = '0;
      ld_ret_data    = '0;
      chkA_rd        = '0;
      chkB_rd        = '0;
      chkD_rd        = '0;
   endtask

   // One clock: inputs are already applied at the falling edge. Combinational
   // outputs are checked before the rising edge, registered ones just after.
   task automatic cycle();
      logic exp_haz;
      bit   acc;
      ld_t  e;
      #1;
      check("ld_ret_ready", ld_ret_ready, (mq.size() < DEPTH));
      exp_haz = mbusy[chkA_rd] | mbusy[chkB_rd] | mbusy[chkD_rd];
`ifdef WB_FORWARD_EN
      check("fwdA_hit", fwdA_hit, exp_we && exp_sel == chkA_rd && chkA_rd != 0);
      check("fwdB_hit", fwdB_hit, exp_we && exp_sel == chkB_rd && chkB_rd != 0);
      if (exp_we && exp_sel == chkA_rd && chkA_rd != 0) check("fwdA_data", fwdA_data, exp_data);
      if (exp_we && exp_sel == chkB_rd && chkB_rd != 0) check("fwdB_data", fwdB_data, exp_data);
`else
      exp_haz = exp_haz | (exp_we && ((exp_sel == chkA_rd && chkA_rd != 0) ||
                                      (exp_sel == chkB_rd && chkB_rd != 0)));
`endif
      check("hazard", hazard, exp_haz);
      @(posedge clk);
      if (reset) begin
         mq.delete();
         mbusy    = '0;
         exp_we   = 1'b0;
         exp_sel  = '0;
         exp_data = '0;
         chk_sel  = 1'b1;
      end else begin
         acc     = ld_ret_valid && (mq.size() < DEPTH);
         exp_we  = 1'b0;
         chk_sel = 1'b0;
         if (alu_valid && alu_rd != 0) begin
            exp_we   = 1'b1;
            exp_sel  = alu_rd;
            exp_data = alu_data;
            chk_sel  = 1'b1;
         end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.rd != 0) begin
               exp_we       = 1'b1;
               exp_sel      = e.rd;
               exp_data     = e.data;
               chk_sel      = 1'b1;
               mbusy[e.rd]  = 1'b0;
            end
         end
         if (ld_issue_valid && ld_issue_rd != 0) mbusy[ld_issue_rd] = 1'b1;
         if (acc) mq.push_back('{ld_ret_rd, ld_ret_data});
      end
      #1;
      check("rf_writeEnable", rf_writeEnable, exp_we);
      if (chk_sel) begin
         check("rf_writeSelect", rf_writeSelect, exp_sel);
         check("rf_dataIn", rf_dataIn, exp_data);
      end
      check("busy_vec", busy_vec, mbusy);
      @(negedge clk);
   endtask

   initial begin
      int pick;
      idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      mq.delete();
      mbusy = '0; exp_we = 1'b0; exp_sel = '0; exp_data = '0; chk_sel = 1'b1;
      check("rst_we", rf_writeEnable, 1'b0);
      check("rst_sel", rf_writeSelect, 5'd0);
      check("rst_data", rf_dataIn, 32'd0);
      check("rst_busy", busy_vec, 32'd0);
      check("rst_ready", ld_ret_ready, 1'b1);
      reset = 1'b0;

      // 1: ALU write appears one cycle later, for one cycle only
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
      cycle();
      check("t1_we", rf_writeEnable, 1'b1);
      check("t1_sel", rf_writeSelect, 5'd5);
      check("t1_data", rf_dataIn, 32'h1234);
      idle();
      cycle();
      check("t1_we_off", rf_writeEnable, 1'b0);

      // 2: load to r7 marks it busy; return lands two cycles later
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
      cycle();
      idle();
      chkA_rd = 5'd7;
      check("t2_busy7", busy_vec[7], 1'b1);
      #1 check("t2_hazard", hazard, 1'b1);
      ld_ret_valid = 1'b1; ld_ret_rd = 5'd7; ld_ret_data = 32'hBEEF;
      cycle();
      check("t2_we_push", rf_writeEnable, 1'b0);
      ld_ret_valid = 1'b0;
      cycle();
      check("t2_we", rf_writeEnable, 1'b1);
      check("t2_data", rf_dataIn, 32'hBEEF);
      check("t2_busy_clr", busy_vec[7], 1'b0);
      cycle();
      idle();
      cycle();

      // 3: fill four returns behind continuous ALU writes, then drain in order
      for (int i = 0; i < 4; i++) begin
         alu_valid = 1'b1; alu_rd = 5'(1 + i); alu_data = 32'(i);
         ld_ret_valid = 1'b1; ld_ret_rd = 5'(10 + i); ld_ret_data = 32'hA000 + 32'(i);
         cycle();
      end
      check("t3_not_ready", ld_ret_ready, 1'b0);
      // 4a: full queue with a pop in the same cycle still refuses the push
      alu_valid = 1'b0;
      ld_ret_rd = 5'd20; ld_ret_data = 32'hDEAD;
      cycle();
      check("t3_fifo0", rf_writeSelect, 5'd10);
      ld_ret_valid = 1'b0;
      for (int i = 1; i < 4; i++) begin
         cycle();
         check("t3_fifo", rf_writeSelect, 5'(10 + i));
      end
      cycle();
      check("t4_refused", rf_writeEnable, 1'b0);

      // 4b: at count 2, push+pop keeps the count at 2
      for (int i = 0; i < 2; i++) begin
         alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'(i);
         ld_ret_valid = 1'b1; ld_ret_rd = 5'(21 + i); ld_ret_data = 32'hB000 + 32'(i);
         cycle();
      end
      alu_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ld_ret_rd = 5'(23 + i); ld_ret_data = 32'hC000 + 32'(i);
         cycle();
      end
      ld_ret_valid = 1'b0;
      repeat (3) cycle();

      // 4c: ten loads through the queue wrap both pointers
      for (int i = 0; i < 10; i++) begin
         ld_ret_valid = 1'b1; ld_ret_rd = 5'(1 + i); ld_ret_data = 32'hD000 + 32'(i);
         cycle();
      end
      idle();
      repeat (2) cycle();

      // 5: r0 writes and issues are swallowed
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF;
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
      cycle();
      check("t5_alu_r0", rf_writeEnable, 1'b0);
      check("t5_busy0", busy_vec, 32'd0);
      idle();
      ld_ret_valid = 1'b1; ld_ret_rd = 5'd0; ld_ret_data = 32'h5555;
      cycle();
      idle();
      cycle();
      check("t5_ld_r0", rf_writeEnable, 1'b0);

      // 6: reset with three queued loads and busy bits set
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'(i);
         ld_issue_valid = 1'b1; ld_issue_rd = 5'(3 + i);
         ld_ret_valid = 1'b1; ld_ret_rd = 5'(3 + i); ld_ret_data = 32'(i);
         cycle();
      end
      idle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      check("t6_busy", busy_vec, 32'd0);
      check("t6_we", rf_writeEnable, 1'b0);
      check("t6_ready", ld_ret_ready, 1'b1);
      cycle();
      check("t6_empty", rf_writeEnable, 1'b0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         idle();
         reset     = ($urandom_range(0, 199) == 0);
         alu_valid = ($urandom_range(0, 2) == 0);
         alu_rd    = REG_AW'($urandom);
         alu_data  = $urandom;
         pick      = $urandom_range(0, 31);
         if (!mbusy[pick] && $urandom_range(0, 2) == 0) begin
            ld_issue_valid = 1'b1;
            ld_issue_rd    = REG_AW'(pick);
         end
         ld_ret_valid = ($urandom_range(0, 1) == 1);
         ld_ret_rd    = REG_AW'($urandom);
         if (mbusy != 0 && $urandom_range(0, 3) != 0) begin
            for (int k = 0; k < 32; k++)
               if (mbusy[(pick + k) % 32]) begin
                  ld_ret_rd = REG_AW'((pick + k) % 32);
                  break;
               end
         end
         ld_ret_data = $urandom;
         chkA_rd = ($urandom_range(0, 3) == 0) ? exp_sel : REG_AW'($urandom);
         chkB_rd = ($urandom_range(0, 3) == 0) ? exp_sel : REG_AW'($urandom);
         chkD_rd = REG_AW'($urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
